// File: rtl/gcd_feeder_pkg.sv
// Shared types and constants for the GCD operand feeder and its key debouncer.
// The build option GCD_FEEDER_TIMEOUT_EN is consumed by gcd_operand_feeder.
package gcd_feeder_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_operand_feeder_if.sv
// Valid/ready operand channel and result channel between the feeder and the GCD core.
// The master modport is the feeder side, the slave modport is the GCD side.
interface gcd_operand_feeder_if #(
  parameter int unsigned DATA_W = 32
);

  logic              gcd_in_valid;
  logic              gcd_in_ready;
  logic [DATA_W-1:0] gcd_in_x;
  logic [DATA_W-1:0] gcd_in_y;
  logic              gcd_out_valid;
  logic [DATA_W-1:0] gcd_out_bits;

  modport master (
    output gcd_in_valid, gcd_in_x, gcd_in_y,
    input  gcd_in_ready, gcd_out_valid, gcd_out_bits
  );

  modport slave (
    input  gcd_in_valid, gcd_in_x, gcd_in_y,
    output gcd_in_ready, gcd_out_valid, gcd_out_bits
  );

endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low push-button and emits a single-cycle
// pulse on each debounced press; shared by all board keys.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic press_pulse
);

  import gcd_feeder_pkg::*;

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = synced;
        press_d = ~synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_n};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = press_q;

endmodule

// File: rtl/gcd_operand_feeder.sv
// Turns a debounced key press into one operand transfer to the GCD core and latches its result.
// Define GCD_FEEDER_TIMEOUT_EN to add a WAIT watchdog that raises error after TIMEOUT_CYCLES.
module gcd_operand_feeder
  import gcd_feeder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned OPER_W          = 8,
  parameter int unsigned DATA_W          = 32
`ifdef GCD_FEEDER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_n,
  input  logic [OPER_W-1:0]        sw_x,
  input  logic [OPER_W-1:0]        sw_y,
  gcd_operand_feeder_if.master     gcd,
  output logic [DATA_W-1:0]        result,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     error
);

  logic [SYNC_STAGES-1:0][OPER_W-1:0] swx_sync_q, swy_sync_q;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rv_q, rv_d;
  logic              key_level;
  logic              press;
  logic              start;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clock       (clock),
    .reset       (reset),
    .raw_n       (key_n),
    .level       (key_level),
    .press_pulse (press)
  );

  // A press pulse is only trusted while the debounced key actually reads pressed.
  assign start = press & ~key_level;

`ifdef GCD_FEEDER_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_width(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    rv_d     = rv_q;
`ifdef GCD_FEEDER_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = DATA_W'(swx_sync_q[SYNC_STAGES-1]);
          y_d     = DATA_W'(swy_sync_q[SYNC_STAGES-1]);
          rv_d    = 1'b0;
`ifdef GCD_FEEDER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (gcd.gcd_in_ready) begin
          state_d  = WAIT;
`ifdef GCD_FEEDER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        if (gcd.gcd_out_valid) begin
          result_d = gcd.gcd_out_bits;
          rv_d     = 1'b1;
          state_d  = IDLE;
        end
`ifdef GCD_FEEDER_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      swx_sync_q <= '0;
      swy_sync_q <= '0;
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      result_q   <= '0;
      rv_q       <= 1'b0;
`ifdef GCD_FEEDER_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      swx_sync_q <= {swx_sync_q[SYNC_STAGES-2:0], sw_x};
      swy_sync_q <= {swy_sync_q[SYNC_STAGES-2:0], sw_y};
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      result_q   <= result_d;
      rv_q       <= rv_d;
`ifdef GCD_FEEDER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign gcd.gcd_in_valid = (state_q == ISSUE);
  assign gcd.gcd_in_x     = x_q;
  assign gcd.gcd_in_y     = y_q;
  assign result           = result_q;
  assign result_valid     = rv_q;
  assign busy             = (state_q != IDLE);
`ifdef GCD_FEEDER_TIMEOUT_EN
  assign error            = err_q;
`else
  assign error            = 1'b0;
`endif

endmodule
